// File: rtl/barrett_operand_mult.sv
// Sequential radix-4 unsigned multiplier feeding the Barrett reducer's wide input.
// Retires two multiplier bits per cycle; fixed latency of OP_W/2+1 cycles from accept to finish.
module barrett_operand_mult #(
    parameter int unsigned OP_W = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [OP_W-1:0]       a_i,
    input  logic [OP_W-1:0]       b_i,
    output logic                  busy_o,
    output logic                  finish_o,
    output logic [2*OP_W-1:0]     product_o
);

    localparam int unsigned PROD_W = 2 * OP_W;
    localparam int unsigned CNT_W  = $clog2(OP_W / 2);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(OP_W / 2 - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e              state_q, state_d;
    logic [OP_W-1:0]     a_q, a_d;
    logic [OP_W+1:0]     a3_q, a3_d;
    logic [OP_W-1:0]     b_q, b_d;
    logic [PROD_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PROD_W-1:0]   product_q, product_d;

    logic [OP_W+1:0]     pp;
    logic [PROD_W-1:0]   pp_ext;
    logic [PROD_W-1:0]   acc_next;

    // Partial product for the current radix-4 digit, placed at bit 2*cnt.
    always_comb begin
        unique case (b_q[1:0])
            2'd0:    pp = '0;
            2'd1:    pp = {2'b00, a_q};
            2'd2:    pp = {1'b0, a_q, 1'b0};
            default: pp = a3_q;
        endcase
        pp_ext   = {{(PROD_W - OP_W - 2){1'b0}}, pp};
        acc_next = acc_q + (pp_ext << {cnt_q, 1'b0});
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        a3_d      = a3_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        unique case (state_q)
            StRun: begin
                acc_d = acc_next;
                b_d   = b_q >> 2;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    product_d = acc_next;
                    state_d   = StDone;
                end
            end
            default: begin
                // IDLE and DONE both accept, which gives back-to-back throughput.
                state_d = StIdle;
                if (start_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    a3_d    = {2'b00, a_i} + {1'b0, a_i, 1'b0};
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            a_q       <= '0;
            a3_q      <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            a3_q      <= a3_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign busy_o    = (state_q == StRun);
    assign finish_o  = (state_q == StDone);
    assign product_o = product_q;

endmodule

// File: tb/tb_barrett_operand_mult.sv
// Self-checking bench: table-driven products through a scoreboard queue, plus
// back-to-back, start-while-busy and reset-mid-operation sequences.
module tb_barrett_operand_mult;

    localparam int OP_W = 32;
    localparam int LAT  = OP_W / 2 + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [OP_W-1:0]   a;
    logic [OP_W-1:0]   b;
    logic              busy;
    logic              finish;
    logic [2*OP_W-1:0] product;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [63:0] exp_q[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
    } vec_t;

    barrett_operand_mult #(.OP_W(OP_W)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .a_i       (a),
        .b_i       (b),
        .busy_o    (busy),
        .finish_o  (finish),
        .product_o (product)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Scoreboard: compare every finish pulse against the oldest expected product.
    always @(negedge clk) begin
        if (!rst && finish) begin
            check("busy_finish_exclusive", {63'd0, busy}, 64'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_finish", 64'd1, 64'd0);
            end else begin
                check("product", product, exp_q.pop_front());
            end
        end
    end

    // Drive a start for one edge; returns the cycle number of RUN cycle 1.
    task automatic do_start(input logic [31:0] av, input logic [31:0] bv, output int t1);
        start = 1'b1;
        a     = av;
        b     = bv;
        exp_q.push_back({32'd0, av} * {32'd0, bv});
        tick();
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        t1    = cyc;
    endtask

    task automatic wait_finish(input string name, input int t1);
        int n = 0;
        while (!finish && n < 3 * LAT) begin
            tick();
            n++;
        end
        if (!finish) check({name, "_timeout"}, 64'd0, 64'd1);
        else         check({name, "_latency"}, 64'(cyc - t1 + 1), 64'(LAT));
    endtask

    vec_t vecs[$];

    initial begin
        int t1;
        int t_first;
        logic seen;

        vecs.push_back('{32'h007FE000, 32'h007FE000, 64'h00003FE004000000});
        vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001});
        vecs.push_back('{32'h00000000, 32'h12345678, 64'h0});
        vecs.push_back('{32'h00000003, 32'h00000003, 64'h9});
        vecs.push_back('{32'h00000001, 32'h80000000, 64'h0000000080000000});
        vecs.push_back('{32'h007FE000, 32'h00000002, 64'h0000000000FFC000});
        vecs.push_back('{32'h00000005, 32'h00000007, 64'h23});
        vecs.push_back('{32'hDEADBEEF, 32'h00000010, 64'h0000000DEADBEEF0});

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        tick();
        tick();
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_finish", {63'd0, finish}, 64'd0);
        check("reset_product", product, 64'd0);
        rst = 1'b0;
        tick();

        // Table vectors: check the table constant against the bench model, then run.
        foreach (vecs[i]) begin
            check("table_model", {32'd0, vecs[i].a} * {32'd0, vecs[i].b}, vecs[i].p);
            do_start(vecs[i].a, vecs[i].b, t1);
            check("busy_after_accept", {63'd0, busy}, 64'd1);
            wait_finish("table", t1);
            check("table_product", product, vecs[i].p);
            tick();
            check("idle_holds_product", product, vecs[i].p);
        end

        for (int i = 0; i < 4; i++) begin
            do_start($urandom, $urandom, t1);
            wait_finish("random", t1);
            tick();
        end

        // Back-to-back: second start held during DONE.
        do_start(32'h007FE000, 32'd2, t1);
        wait_finish("b2b_first", t1);
        t_first = cyc;
        do_start(32'd5, 32'd7, t1);
        check("b2b_busy_rises", {63'd0, busy}, 64'd1);
        for (int i = 0; i < 8; i++) tick();
        check("b2b_product_held", product, 64'h0000000000FFC000);
        wait_finish("b2b_second", t1);
        check("b2b_spacing", 64'(cyc - t_first), 64'(LAT));
        check("b2b_second_product", product, 64'h23);
        tick();

        // Start while busy is ignored.
        do_start(32'h00012345, 32'h00006789, t1);
        while (cyc < t1 + 4) tick();
        start = 1'b1;
        a     = 32'hFFFFFFFF;
        b     = 32'hFFFFFFFF;
        tick();
        start = 1'b0;
        wait_finish("busy_start", t1);
        check("busy_start_product", product, 64'h00012345 * 64'h00006789);
        tick();
        check("busy_start_no_rerun", {63'd0, busy}, 64'd0);

        // Reset mid-operation.
        do_start(32'h00ABCDEF, 32'h00FEDCBA, t1);
        while (cyc < t1 + 7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_finish", {63'd0, finish}, 64'd0);
        check("midrst_product", product, 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 2 * LAT; i++) begin
            tick();
            seen |= finish;
        end
        check("midrst_no_finish", {63'd0, seen}, 64'd0);
        do_start(32'h00000011, 32'h00000013, t1);
        wait_finish("post_rst", t1);
        check("post_rst_product", product, 64'd323);
        tick();
        tick();

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
